// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 set-2 key controller.
//   SC_EXT  : extended-key prefix byte
//   SC_BRK  : break (key release) prefix byte
//   kbd_state_e : scancode sequencer states
package kbd_pkg;
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_e;
endpackage

// File: rtl/kbd_event_slot.sv
// One-entry valid/ready holding register for key events {key, ascii, rpt}.
// A load on the same edge as a consumer accept replaces the entry.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             write a new entry this edge
//   load_key/ascii/rpt  entry contents
//   ev_ready         consumer accepts the held entry
//   ev_valid/key/ascii/rpt  held entry
module kbd_event_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_key,
    input  logic [7:0] load_ascii,
    input  logic       load_rpt,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [7:0] ev_key,
    output logic [7:0] ev_ascii,
    output logic       ev_rpt
);
    logic       valid_q, valid_d;
    logic [7:0] key_q, key_d;
    logic [7:0] ascii_q, ascii_d;
    logic       rpt_q, rpt_d;

    always_comb begin
        valid_d = load | (valid_q & ~ev_ready);
        key_d   = load ? load_key   : key_q;
        ascii_d = load ? load_ascii : ascii_q;
        rpt_d   = load ? load_rpt   : rpt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            key_q   <= 8'h00;
            ascii_q <= 8'h00;
            rpt_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            ascii_q <= ascii_d;
            rpt_q   <= rpt_d;
        end
    end

    assign ev_valid = valid_q;
    assign ev_key   = key_q;
    assign ev_ascii = ascii_q;
    assign ev_rpt   = rpt_q;
endmodule

// File: rtl/keycode_to_ascii.sv
// Set-2 make code to ASCII lookup (upper-case letters, digits, space).
// Ports:
//   code  in  8  set-2 make code
//   ascii out 8  ASCII character, 0x00 when the code has no mapping
module keycode_to_ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);
    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = "A";  8'h32: ascii = "B";  8'h21: ascii = "C";
            8'h23: ascii = "D";  8'h24: ascii = "E";  8'h2B: ascii = "F";
            8'h34: ascii = "G";  8'h33: ascii = "H";  8'h43: ascii = "I";
            8'h3B: ascii = "J";  8'h42: ascii = "K";  8'h4B: ascii = "L";
            8'h3A: ascii = "M";  8'h31: ascii = "N";  8'h44: ascii = "O";
            8'h4D: ascii = "P";  8'h15: ascii = "Q";  8'h2D: ascii = "R";
            8'h1B: ascii = "S";  8'h2C: ascii = "T";  8'h3C: ascii = "U";
            8'h2A: ascii = "V";  8'h1D: ascii = "W";  8'h22: ascii = "X";
            8'h35: ascii = "Y";  8'h1A: ascii = "Z";
            8'h45: ascii = "0";  8'h16: ascii = "1";  8'h1E: ascii = "2";
            8'h26: ascii = "3";  8'h25: ascii = "4";  8'h2E: ascii = "5";
            8'h36: ascii = "6";  8'h3D: ascii = "7";  8'h3E: ascii = "8";
            8'h46: ascii = "9";  8'h29: ascii = " ";
            default: ascii = 8'h00;
        endcase
    end
endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scancode sequencer: tracks the held key, counts presses and
// emits one event per make code (new press or typematic repeat).
// Build option: define KBD_REPEAT_FILTER_EN to drop typematic repeats silently.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_data/in_ready  scancode byte stream from the PS/2 receiver
//   key_down, cur_key, cur_ascii  held / last key state
//   press_cnt             count of new presses (wraps)
//   ev_valid/ev_ready/ev_key/ev_ascii/ev_rpt  event stream
//
// state   | meaning
// IDLE    | no prefix pending; next byte is a prefix or a make code
// BRK     | F0 seen; next byte is the released key
// EXT     | E0 seen; next byte is an extended make or F0
// EXT_BRK | E0 F0 seen; next byte is an extended release (ignored)
module ps2_key_ctrl
    import kbd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             key_down,
    output logic [7:0]       cur_key,
    output logic [7:0]       cur_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_key,
    output logic [7:0]       ev_ascii,
    output logic             ev_rpt
);
    kbd_state_e       state_q, state_d;
    logic             key_down_q, key_down_d;
    logic [7:0]       cur_key_q, cur_key_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;

    logic       accept;
    logic       ev_load;
    logic       ev_load_rpt;
    logic [7:0] in_ascii;

    assign in_ready = ~ev_valid | ev_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_down_q  <= 1'b0;
            cur_key_q   <= 8'h00;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            key_down_q  <= key_down_d;
            cur_key_q   <= cur_key_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_data == SC_EXT)      state_d = EXT;
                    else if (in_data == SC_BRK) state_d = BRK;
                end
                EXT:     state_d = (in_data == SC_BRK) ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        key_down_d  = key_down_q;
        cur_key_d   = cur_key_q;
        press_cnt_d = press_cnt_q;
        ev_load     = 1'b0;
        ev_load_rpt = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_data != SC_EXT && in_data != SC_BRK) begin
                        if (!key_down_q || in_data != cur_key_q) begin
                            cur_key_d   = in_data;
                            key_down_d  = 1'b1;
                            press_cnt_d = press_cnt_q + 1'b1;
                            ev_load     = 1'b1;
                        end else begin
`ifndef KBD_REPEAT_FILTER_EN
                            ev_load     = 1'b1;
                            ev_load_rpt = 1'b1;
`endif
                        end
                    end
                end
                BRK: begin
                    if (key_down_q && in_data == cur_key_q) key_down_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    keycode_to_ascii u_cur_lut (
        .code  (cur_key_q),
        .ascii (cur_ascii)
    );

    // A repeat's key equals in_data, so the event lookup always runs on the incoming byte.
    keycode_to_ascii u_ev_lut (
        .code  (in_data),
        .ascii (in_ascii)
    );

    kbd_event_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (ev_load),
        .load_key   (in_data),
        .load_ascii (in_ascii),
        .load_rpt   (ev_load_rpt),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_key     (ev_key),
        .ev_ascii   (ev_ascii),
        .ev_rpt     (ev_rpt)
    );

    assign key_down  = key_down_q;
    assign cur_key   = cur_key_q;
    assign press_cnt = press_cnt_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       key_down;
    logic [7:0] cur_key;
    logic [7:0] cur_ascii;
    logic [7:0] press_cnt;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_key;
    logic [7:0] ev_ascii;
    logic       ev_rpt;

    ps2_key_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .key_down(key_down), .cur_key(cur_key),
        .cur_ascii(cur_ascii), .press_cnt(press_cnt), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_key(ev_key), .ev_ascii(ev_ascii), .ev_rpt(ev_rpt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        logic [7:0] ascii;
        logic       rpt;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int  ev_seen = 0;

    // reference model state
    bit         m_held;
    logic [7:0] m_last;
    logic [7:0] m_cnt;
    bit         m_ext, m_brk;

    function automatic logic [7:0] ref_ascii(input logic [7:0] c);
        string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";
        logic [7:0] codes [37] = '{
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
            8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
            8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
            8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
            8'h29};
        for (int i = 0; i < 37; i++)
            if (codes[i] == c) return chars[i];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 0; m_last = 8'h00; m_cnt = 8'h00; m_ext = 0; m_brk = 0;
        exp_q.delete();
    endtask

    task automatic push_ev(input logic [7:0] k, input logic r);
        ev_t e;
        e.key = k; e.ascii = ref_ascii(k); e.rpt = r;
        exp_q.push_back(e);
    endtask

    // Byte-level rules of the set-2 protocol, kept as two prefix flags.
    task automatic model_byte(input logic [7:0] b);
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1; else m_ext = 0;
        end else if (m_brk) begin
            if (m_held && b == m_last) m_held = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_held || b != m_last) begin
            m_last = b; m_held = 1; m_cnt = m_cnt + 8'd1;
            push_ev(b, 1'b0);
        end else begin
`ifndef KBD_REPEAT_FILTER_EN
            push_ev(b, 1'b1);
`endif
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_key_down", key_down, 0);
        chk("rst_cur_key", cur_key, 0);
        chk("rst_cur_ascii", cur_ascii, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_key", ev_key, 0);
        chk("rst_ev_ascii", ev_ascii, 0);
        chk("rst_ev_rpt", ev_rpt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was taken.
    task automatic send(input logic [7:0] b);
        bit acc = 0;
        in_valid = 1; in_data = b;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!acc) begin
            chk("send_timeout", 0, 1);
            return;
        end
        model_byte(b);
        chk("key_down", key_down, m_held);
        chk("cur_key", cur_key, m_last);
        chk("cur_ascii", cur_ascii, ref_ascii(m_last));
        chk("press_cnt", press_cnt, m_cnt);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       ev_ready = 1'($urandom_range(0, 1));
            2:       ev_ready = 1'b0;
            default: ev_ready = 1'b1;
        endcase
    end

    // Scoreboard monitor: an event is consumed on the next edge when valid && ready.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ev_valid", ev_valid, (exp_q.size() != 0) ? 1 : 0);
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    chk("ev_unexpected", {ev_key, ev_ascii}, 16'h0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    ev_seen++;
                    chk("ev_payload", {ev_key, ev_ascii, 7'd0, ev_rpt},
                        {e.key, e.ascii, 7'd0, e.rpt});
                end
            end
        end
    end

    logic [7:0] pool [10] = '{8'h1C, 8'h32, 8'h16, 8'h21, 8'hE0, 8'hF0, 8'h75, 8'h77, 8'h29, 8'h45};
    int base;

    initial begin
        model_reset();
        do_reset();

        // press and release A
        rdy_mode = 1;
        base = ev_seen;
        send(8'h1C);
        chk("t2_down", key_down, 1);
        send(8'hF0); send(8'h1C);
        chk("t2_up", key_down, 0);
        drain();
        chk("t2_events", ev_seen - base, 1);

        // typematic repeats
        base = ev_seen;
        send(8'h16); send(8'h16); send(8'h16); send(8'hF0); send(8'h16);
        drain();
`ifdef KBD_REPEAT_FILTER_EN
        chk("t3_events", ev_seen - base, 1);
`else
        chk("t3_events", ev_seen - base, 3);
`endif

        // extended make/break is transparent
        base = ev_seen;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain();
        chk("t4_events", ev_seen - base, 0);

        // back-pressure: second make stalls until the consumer is ready
        do_reset();
        rdy_mode = 2;
        send(8'h1C);
        chk("t5_in_ready", in_ready, 0);
        fork
            send(8'h32);
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("t5_stall_cnt", press_cnt, 1);
                rdy_mode = 1;
            end
        join
        drain();

        // counter wrap
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 255; i++) send((i % 2) ? 8'h32 : 8'h1C);
        chk("t6_cnt_255", press_cnt, 255);
        send(8'h21);
        chk("t6_cnt_wrap", press_cnt, 0);
        drain();

        // reset drops a pending break prefix
        send(8'hF0);
        do_reset();
        base = ev_seen;
        send(8'h21);
        chk("t6_rst_make", key_down, 1);
        drain();
        chk("t6_rst_events", ev_seen - base, 1);

        // randomized traffic
        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            send(pool[$urandom_range(0, 9)]);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
